// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 16x16 register file: clears R0..R15 after reset, then
// shares the port between writeback (priority) and a small buffered cache-fill path.
module rf_write_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [3:0]  wb_reg,
   input  logic [15:0] wb_data,
   output logic        wb_stall,
   input  logic        fill_valid,
   input  logic [3:0]  fill_reg,
   input  logic [15:0] fill_data,
   output logic        fill_ready,
   output logic        rf_write_en,
   output logic [3:0]  rf_dst_reg,
   output logic [15:0] rf_dst_data,
   output logic        init_busy,
   output logic [15:0] pend_mask
);

   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CW   = PTRW + 1;
   localparam int SW   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {INIT, RUN} stateType;

   stateType              state;
   logic [3:0]            initCnt;
   logic [3:0]            regQ  [FIFO_DEPTH];
   logic [15:0]           dataQ [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] liveQ;
   logic [FIFO_DEPTH-1:0] killQ;
   logic [PTRW-1:0]       rdPtr;
   logic [PTRW-1:0]       wrPtr;
   logic [CW-1:0]         fifoCount;
   logic [SW-1:0]         starveCnt;

   logic                  isRun;
   logic                  fifoEmpty;
   logic                  fifoFull;
   logic                  pushEn;
   logic                  wbWin;
   logic                  popEn;
   logic                  headWrites;
   logic [3:0]            regN  [FIFO_DEPTH];
   logic [15:0]           dataN [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] liveN;
   logic [FIFO_DEPTH-1:0] killN;
   logic [15:0]           pendN;
   logic [SW-1:0]         starveN;

   assign isRun      = (state == RUN);
   assign fifoEmpty  = (fifoCount == '0);
   assign fifoFull   = (fifoCount == CW'(FIFO_DEPTH));
   assign fill_ready = isRun && !fifoFull;
   assign pushEn     = fill_valid && fill_ready;
   assign wbWin      = isRun && wb_valid && !wb_stall;
   assign popEn      = isRun && !wbWin && !fifoEmpty;
   assign headWrites = !killQ[rdPtr] && (regQ[rdPtr] != 4'd0);

   // Next FIFO contents after this edge's pop, push and kill; the pending mask is
   // derived from that post-update view so it can be registered directly.
   always_comb begin
      regN  = regQ;
      dataN = dataQ;
      liveN = liveQ;
      killN = killQ;
      pendN = '0;
      if (popEn) begin
         liveN[rdPtr] = 1'b0;
      end
      if (pushEn) begin
         liveN[wrPtr] = 1'b1;
         killN[wrPtr] = 1'b0;
         regN[wrPtr]  = fill_reg;
         dataN[wrPtr] = fill_data;
      end
      if (wbWin) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (liveN[i] && (regN[i] == wb_reg)) begin
               killN[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (liveN[i] && !killN[i]) begin
            pendN[regN[i]] = 1'b1;
         end
      end
   end

   // Killed pops are not real wins, so they leave the starvation count alone;
   // the stall cycle itself always clears it.
   always_comb begin
      starveN = starveCnt;
      if (fifoEmpty || wb_stall || (popEn && !killQ[rdPtr])) begin
         starveN = '0;
      end else if (wbWin) begin
         starveN = starveCnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= INIT;
         initCnt     <= '0;
         init_busy   <= 1'b1;
         rf_write_en <= 1'b0;
         rf_dst_reg  <= '0;
         rf_dst_data <= '0;
         wb_stall    <= 1'b0;
         pend_mask   <= '0;
         regQ        <= '{default: '0};
         dataQ       <= '{default: '0};
         liveQ       <= '0;
         killQ       <= '0;
         rdPtr       <= '0;
         wrPtr       <= '0;
         fifoCount   <= '0;
         starveCnt   <= '0;
      end else begin
         case (state)
            INIT: begin
               rf_write_en <= 1'b1;
               rf_dst_reg  <= initCnt;
               rf_dst_data <= '0;
               initCnt     <= initCnt + 4'd1;
               if (initCnt == 4'd15) begin
                  state     <= RUN;
                  init_busy <= 1'b0;
               end
            end
            RUN: begin
               if (wbWin) begin
                  rf_write_en <= (wb_reg != 4'd0);
                  rf_dst_reg  <= wb_reg;
                  rf_dst_data <= wb_data;
               end else if (popEn) begin
                  rf_write_en <= headWrites;
                  rf_dst_reg  <= regQ[rdPtr];
                  rf_dst_data <= dataQ[rdPtr];
               end else begin
                  rf_write_en <= 1'b0;
               end
            end
            default: state <= INIT;
         endcase
         regQ      <= regN;
         dataQ     <= dataN;
         liveQ     <= liveN;
         killQ     <= killN;
         pend_mask <= pendN;
         if (popEn) rdPtr <= rdPtr + PTRW'(1);
         if (pushEn) wrPtr <= wrPtr + PTRW'(1);
         fifoCount <= fifoCount + CW'(pushEn) - CW'(popEn);
         starveCnt <= starveN;
         wb_stall  <= isRun && (starveN == SW'(STARVE_LIMIT));
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter: clear sequence, WB priority, FILL buffering,
// kill ordering, starvation stall and mid-operation reset.
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        wb_stall;
   logic        fill_valid;
   logic [3:0]  fill_reg;
   logic [15:0] fill_data;
   logic        fill_ready;
   logic        rf_write_en;
   logic [3:0]  rf_dst_reg;
   logic [15:0] rf_dst_data;
   logic        init_busy;
   logic [15:0] pend_mask;

   logic [20:0] port;
   logic [20:0] expPort;
   logic [2:0]  status;
   int          checks;
   int          errors;

   assign port   = {rf_write_en, rf_dst_reg, rf_dst_data};
   assign status = {init_busy, fill_ready, wb_stall};

   rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
      .fill_valid(fill_valid), .fill_reg(fill_reg), .fill_data(fill_data), .fill_ready(fill_ready),
      .rf_write_en(rf_write_en), .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
      .init_busy(init_busy), .pend_mask(pend_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wv, input logic [3:0] wr, input logic [15:0] wd,
                                input logic fv, input logic [3:0] fr, input logic [15:0] fd);
      wb_valid   = wv;
      wb_reg     = wr;
      wb_data    = wd;
      fill_valid = fv;
      fill_reg   = fr;
      fill_data  = fd;
   endtask

   task automatic run_init(input string tag);
      for (int k = 0; k < 16; k++) begin
         tick();
         expPort = {1'b1, 4'(k), 16'h0000};
         checks++;
         if (port !== expPort) begin
            errors++;
            $display("[TB] FAIL %s_clear%0d: got %h expected %h", tag, k, port, expPort);
         end
         checks++;
         if (init_busy !== (k != 15)) begin
            errors++;
            $display("[TB] FAIL %s_busy%0d: got %b expected %b", tag, k, init_busy, (k != 15));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      #12;
      checks++;
      if (port !== 21'h0) begin
         errors++;
         $display("[TB] FAIL reset_port: got %h expected %h", port, 21'h0);
      end
      checks++;
      if (status !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_status: got %b expected %b", status, 3'b100);
      end
      checks++;
      if (pend_mask !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_pend: got %h expected %h", pend_mask, 16'h0);
      end
      tick();
      rst = 1'b1;
      run_init("init");
      checks++;
      if (fill_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL init_ready: got %b expected 1", fill_ready);
      end
      tick();
      expPort = {1'b0, 4'd15, 16'h0000};
      checks++;
      if (port !== expPort) begin
         errors++;
         $display("[TB] FAIL idle_hold: got %h expected %h", port, expPort);
      end
   endtask

   task automatic test_wb();
      applyStimulus(1, 4'd5, 16'hBEEF, 0, 0, 0);
      tick();
      expPort = {1'b1, 4'd5, 16'hBEEF};
      checks++;
      if (port !== expPort) begin
         errors++;
         $display("[TB] FAIL wb_r5: got %h expected %h", port, expPort);
      end
      applyStimulus(1, 4'd0, 16'h1234, 0, 0, 0);
      tick();
      checks++;
      if (rf_write_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wb_r0: got %b expected 0", rf_write_en);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (rf_write_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wb_idle: got %b expected 0", rf_write_en);
      end
   endtask

   task automatic test_concurrent();
      applyStimulus(1, 4'd3, 16'h1111, 1, 4'd7, 16'h2222);
      tick();
      expPort = {1'b1, 4'd3, 16'h1111};
      checks++;
      if (port !== expPort) begin
         errors++;
         $display("[TB] FAIL conc_wb: got %h expected %h", port, expPort);
      end
      checks++;
      if (pend_mask !== 16'h0080) begin
         errors++;
         $display("[TB] FAIL conc_pend: got %h expected %h", pend_mask, 16'h0080);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      expPort = {1'b1, 4'd7, 16'h2222};
      checks++;
      if (port !== expPort) begin
         errors++;
         $display("[TB] FAIL conc_fill: got %h expected %h", port, expPort);
      end
      checks++;
      if (pend_mask !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL conc_pend_clr: got %h expected %h", pend_mask, 16'h0000);
      end
      tick();
      checks++;
      if (rf_write_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL conc_idle: got %b expected 0", rf_write_en);
      end
   endtask

   task automatic test_kill();
      applyStimulus(0, 0, 0, 1, 4'd9, 16'h5555);
      tick();
      checks++;
      if (pend_mask !== 16'h0200) begin
         errors++;
         $display("[TB] FAIL kill_pend: got %h expected %h", pend_mask, 16'h0200);
      end
      applyStimulus(1, 4'd9, 16'hAAAA, 0, 0, 0);
      tick();
      expPort = {1'b1, 4'd9, 16'hAAAA};
      checks++;
      if (port !== expPort) begin
         errors++;
         $display("[TB] FAIL kill_wb: got %h expected %h", port, expPort);
      end
      checks++;
      if (pend_mask !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL kill_pend_clr: got %h expected %h", pend_mask, 16'h0000);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (rf_write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_nowrite%0d: got %b expected 0", k, rf_write_en);
         end
      end
   endtask

   task automatic test_starve();
      logic        wv [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      logic [3:0]  wr [9] = '{1, 2, 3, 4, 5, 6, 6, 0, 0};
      logic        fv [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      logic [3:0]  fr [9] = '{10, 11, 12, 12, 12, 12, 12, 0, 0};
      logic [20:0] ep [9] = '{{1'b1, 4'd1, 16'h0101}, {1'b1, 4'd2, 16'h0202}, {1'b1, 4'd3, 16'h0303},
                              {1'b1, 4'd4, 16'h0404}, {1'b1, 4'd5, 16'h0505}, {1'b1, 4'd10, 16'hA0A0},
                              {1'b1, 4'd6, 16'h0606}, {1'b1, 4'd11, 16'hB0B0}, {1'b1, 4'd12, 16'hC0C0}};
      logic        es [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      logic        er [9] = '{1, 0, 0, 0, 0, 1, 0, 1, 1};
      logic [15:0] em [9] = '{16'h0400, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00,
                              16'h0800, 16'h1800, 16'h1000, 16'h0000};
      for (int s = 0; s < 9; s++) begin
         applyStimulus(wv[s], wr[s], {2{4'h0, wr[s]}}, fv[s], fr[s], {2{fr[s], 4'h0}});
         tick();
         checks++;
         if (port !== ep[s]) begin
            errors++;
            $display("[TB] FAIL starve_port%0d: got %h expected %h", s, port, ep[s]);
         end
         checks++;
         if (wb_stall !== es[s]) begin
            errors++;
            $display("[TB] FAIL starve_stall%0d: got %b expected %b", s, wb_stall, es[s]);
         end
         checks++;
         if (fill_ready !== er[s]) begin
            errors++;
            $display("[TB] FAIL starve_ready%0d: got %b expected %b", s, fill_ready, er[s]);
         end
         checks++;
         if (pend_mask !== em[s]) begin
            errors++;
            $display("[TB] FAIL starve_pend%0d: got %h expected %h", s, pend_mask, em[s]);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      applyStimulus(1, 4'd2, 16'h2222, 1, 4'd13, 16'hDDDD);
      tick();
      applyStimulus(1, 4'd2, 16'h2223, 1, 4'd14, 16'hEEEE);
      tick();
      checks++;
      if (pend_mask !== 16'h6000) begin
         errors++;
         $display("[TB] FAIL mid_pend: got %h expected %h", pend_mask, 16'h6000);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (port !== 21'h0) begin
         errors++;
         $display("[TB] FAIL mid_port: got %h expected %h", port, 21'h0);
      end
      checks++;
      if (status !== 3'b100) begin
         errors++;
         $display("[TB] FAIL mid_status: got %b expected %b", status, 3'b100);
      end
      checks++;
      if (pend_mask !== 16'h0) begin
         errors++;
         $display("[TB] FAIL mid_pend_clr: got %h expected %h", pend_mask, 16'h0);
      end
      tick();
      tick();
      checks++;
      if (port !== 21'h0) begin
         errors++;
         $display("[TB] FAIL mid_held: got %h expected %h", port, 21'h0);
      end
      rst = 1'b1;
      run_init("reinit");
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (rf_write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_nofill%0d: got %b expected 0", k, rf_write_en);
         end
      end
      checks++;
      if ({fill_ready, pend_mask} !== {1'b1, 16'h0}) begin
         errors++;
         $display("[TB] FAIL mid_run: got %h expected %h", {fill_ready, pend_mask}, {1'b1, 16'h0});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_wb();
      test_concurrent();
      test_kill();
      test_starve();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
